// File: rtl/wb_stage_writer.sv
// wb_stage_writer: W-stage pipeline register and writeback formatter.
// Captures M-stage results, formats the GRF write data (ALU, load
// extract/extend, link PC+8, optional HI/LO) and drives the single GRF
// write port. It also exposes the W-stage result for forwarding and
// counts committed register writes.
// Optional feature macro: WB_HILO_EN (M_WDSel=3 selects the MDU HI/LO value).
// Without it, M_WDSel=3 is captured as a bubble.
module wb_stage_writer #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             M_valid,
  input  logic [31:0]      M_PC,
  input  logic             M_RegWrite,
  input  logic [4:0]       M_A3,
  input  logic [31:0]      M_ALUOut,
  input  logic [31:0]      M_DMRD,
  input  logic [1:0]       M_WDSel,
  input  logic [2:0]       M_LoadType,
  input  logic [31:0]      M_HILO,
  output logic             W_WE,
  output logic [4:0]       W_A3,
  output logic [31:0]      W_WD,
  output logic [31:0]      W_PC,
  output logic             W_fwd_hit,
  output logic [CNT_W-1:0] W_commits
);

  localparam logic [1:0] SEL_ALU  = 2'd0;
  localparam logic [1:0] SEL_DM   = 2'd1;
  localparam logic [1:0] SEL_LINK = 2'd2;

  localparam logic [2:0] LD_LW  = 3'd0;
  localparam logic [2:0] LD_LB  = 3'd1;
  localparam logic [2:0] LD_LBU = 3'd2;
  localparam logic [2:0] LD_LH  = 3'd3;
  localparam logic [2:0] LD_LHU = 3'd4;

  // W-stage pipeline state
  logic             valid_reg;
  logic             regwrite_reg;
  logic [4:0]       a3_reg;
  logic [31:0]      pc_reg;
  logic [31:0]      aluout_reg;
  logic [31:0]      dmrd_reg;
  logic [1:0]       wdsel_reg;
  logic [2:0]       loadtype_reg;
  logic [CNT_W-1:0] commits_reg;

  // Whether the incoming M-stage slot is a real instruction for this build
  logic capture_valid;
  logic we;
  logic [31:0] load_data;
  logic [31:0] wd_sel;

`ifdef WB_HILO_EN
  logic [31:0] hilo_reg;

  // HI/LO read value rides along with the rest of the instruction
  always_ff @(posedge clk) begin
    if (reset) begin
      hilo_reg <= 32'd0;
    end else if (M_valid) begin
      hilo_reg <= M_HILO;
    end else begin
      hilo_reg <= 32'd0;
    end
  end

  assign capture_valid = M_valid;
`else
  // HI/LO selection is unsupported here: such an instruction becomes a bubble
  // so it never writes the GRF or bumps the commit counter.
  logic unused_hilo;
  assign unused_hilo   = ^M_HILO;
  assign capture_valid = M_valid && (M_WDSel != 2'd3);
`endif

  // Capture the M stage each cycle; bubbles store a clean, inert slot
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_reg    <= 1'b0;
      regwrite_reg <= 1'b0;
      a3_reg       <= 5'd0;
      pc_reg       <= RESET_PC;
      aluout_reg   <= 32'd0;
      dmrd_reg     <= 32'd0;
      wdsel_reg    <= 2'd0;
      loadtype_reg <= 3'd0;
    end else if (capture_valid) begin
      valid_reg    <= 1'b1;
      regwrite_reg <= M_RegWrite;
      a3_reg       <= M_A3;
      pc_reg       <= M_PC;
      aluout_reg   <= M_ALUOut;
      dmrd_reg     <= M_DMRD;
      wdsel_reg    <= M_WDSel;
      loadtype_reg <= M_LoadType;
    end else begin
      valid_reg    <= 1'b0;
      regwrite_reg <= 1'b0;
      a3_reg       <= 5'd0;
      pc_reg       <= RESET_PC;
      aluout_reg   <= 32'd0;
      dmrd_reg     <= 32'd0;
      wdsel_reg    <= 2'd0;
      loadtype_reg <= 3'd0;
    end
  end

  // Commit counter: one tick per edge on which the GRF is actually written
  always_ff @(posedge clk) begin
    if (reset) begin
      commits_reg <= '0;
    end else if (we) begin
      commits_reg <= commits_reg + CNT_W'(1);
    end
  end

  // Byte lanes of the loaded word, lane i = bits [8i+7:8i]
  logic [7:0] byte_lane [4];
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_byte_lane
      assign byte_lane[gi] = dmrd_reg[8*gi +: 8];
    end
  endgenerate

  logic [1:0]  load_off;
  logic [7:0]  load_byte;
  logic [15:0] load_half;
  assign load_off  = aluout_reg[1:0];
  assign load_byte = byte_lane[load_off];
  // Halfword loads use offset bit 1 only; bit 0 is ignored
  assign load_half = load_off[1] ? dmrd_reg[31:16] : dmrd_reg[15:0];

  // Load extractor: pick byte/half/word and sign- or zero-extend
  always_comb begin
    load_data = dmrd_reg;
    case (loadtype_reg)
      LD_LW:   load_data = dmrd_reg;
      LD_LB:   load_data = {{24{load_byte[7]}}, load_byte};
      LD_LBU:  load_data = {24'd0, load_byte};
      LD_LH:   load_data = {{16{load_half[15]}}, load_half};
      LD_LHU:  load_data = {16'd0, load_half};
      default: load_data = dmrd_reg;
    endcase
  end

  // Writeback data select; PC+8 wraps naturally at 2^32
  always_comb begin
    wd_sel = aluout_reg;
    case (wdsel_reg)
      SEL_ALU:  wd_sel = aluout_reg;
      SEL_DM:   wd_sel = load_data;
      SEL_LINK: wd_sel = pc_reg + 32'd8;
`ifdef WB_HILO_EN
      default:  wd_sel = hilo_reg;
`else
      default:  wd_sel = 32'd0;
`endif
    endcase
  end

  // $0 is never written; address and data read as zero when not writing
  assign we        = valid_reg && regwrite_reg && (a3_reg != 5'd0);
  assign W_WE      = we;
  assign W_A3      = we ? a3_reg : 5'd0;
  assign W_WD      = we ? wd_sel : 32'd0;
  assign W_PC      = pc_reg;
  assign W_fwd_hit = we;
  assign W_commits = commits_reg;

endmodule

// File: tb/tb_wb_stage_writer.sv
// Directed bench for wb_stage_writer: reset state, each writeback source,
// load extraction, $0 suppression, bubbles, commit counting, reset priority
// and the HI/LO select in whichever build is compiled.
module tb_wb_stage_writer;

  logic        clk;
  logic        reset;
  logic        M_valid;
  logic [31:0] M_PC;
  logic        M_RegWrite;
  logic [4:0]  M_A3;
  logic [31:0] M_ALUOut;
  logic [31:0] M_DMRD;
  logic [1:0]  M_WDSel;
  logic [2:0]  M_LoadType;
  logic [31:0] M_HILO;
  logic        W_WE;
  logic [4:0]  W_A3;
  logic [31:0] W_WD;
  logic [31:0] W_PC;
  logic        W_fwd_hit;
  logic [31:0] W_commits;

  int n_checks = 0;
  int n_fail   = 0;

  wb_stage_writer #(
    .RESET_PC(32'h0000_3000),
    .CNT_W(32)
  ) dut (
    .clk(clk),
    .reset(reset),
    .M_valid(M_valid),
    .M_PC(M_PC),
    .M_RegWrite(M_RegWrite),
    .M_A3(M_A3),
    .M_ALUOut(M_ALUOut),
    .M_DMRD(M_DMRD),
    .M_WDSel(M_WDSel),
    .M_LoadType(M_LoadType),
    .M_HILO(M_HILO),
    .W_WE(W_WE),
    .W_A3(W_A3),
    .W_WD(W_WD),
    .W_PC(W_PC),
    .W_fwd_hit(W_fwd_hit),
    .W_commits(W_commits)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after a rising edge, outputs are sampled there too
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic rw,
                       input logic [4:0] a3, input logic [31:0] alu,
                       input logic [1:0] sel, input logic [2:0] lt);
    M_valid    = v;
    M_PC       = pc;
    M_RegWrite = rw;
    M_A3       = a3;
    M_ALUOut   = alu;
    M_WDSel    = sel;
    M_LoadType = lt;
  endtask

  task automatic bubble();
    drive(1'b0, 32'h0, 1'b0, 5'd0, 32'h0, 2'd0, 3'd0);
  endtask

  initial begin
    reset  = 1'b1;
    M_DMRD = 32'h80FF_7F01;
    M_HILO = 32'h0000_DEAD;
    bubble();
    tick();
    tick();
    chk("rst_we",      {31'd0, W_WE}, 32'd0);
    chk("rst_a3",      {27'd0, W_A3}, 32'd0);
    chk("rst_wd",      W_WD, 32'd0);
    chk("rst_pc",      W_PC, 32'h0000_3000);
    chk("rst_fwd",     {31'd0, W_fwd_hit}, 32'd0);
    chk("rst_commits", W_commits, 32'd0);

    reset = 1'b0;
    // addu $8
    drive(1'b1, 32'h3000, 1'b1, 5'd8, 32'h1234, 2'd0, 3'd0);
    tick();
    chk("addu_we",  {31'd0, W_WE}, 32'd1);
    chk("addu_a3",  {27'd0, W_A3}, 32'd8);
    chk("addu_wd",  W_WD, 32'h1234);
    chk("addu_pc",  W_PC, 32'h3000);
    chk("addu_fwd", {31'd0, W_fwd_hit}, 32'd1);
    chk("addu_cnt", W_commits, 32'd0);

    // Loads from word 80FF_7F01
    drive(1'b1, 32'h3004, 1'b1, 5'd9, 32'h0000_0103, 2'd1, 3'd1);
    tick();
    chk("lb3_wd",  W_WD, 32'hFFFF_FF80);
    chk("lb3_cnt", W_commits, 32'd1);
    drive(1'b1, 32'h3008, 1'b1, 5'd9, 32'h0000_0103, 2'd1, 3'd2);
    tick();
    chk("lbu3_wd", W_WD, 32'h0000_0080);
    drive(1'b1, 32'h300C, 1'b1, 5'd9, 32'h0000_0102, 2'd1, 3'd3);
    tick();
    chk("lh2_wd",  W_WD, 32'hFFFF_80FF);
    drive(1'b1, 32'h3010, 1'b1, 5'd9, 32'h0000_0100, 2'd1, 3'd4);
    tick();
    chk("lhu0_wd", W_WD, 32'h0000_7F01);
    drive(1'b1, 32'h3014, 1'b1, 5'd9, 32'h0000_0103, 2'd1, 3'd5);
    tick();
    chk("lt5_wd",  W_WD, 32'h80FF_7F01);
    drive(1'b1, 32'h3018, 1'b1, 5'd9, 32'h0000_0103, 2'd1, 3'd3);
    tick();
    chk("lh3_wd",  W_WD, 32'hFFFF_80FF);
    drive(1'b1, 32'h301C, 1'b1, 5'd9, 32'h0000_0101, 2'd1, 3'd1);
    tick();
    chk("lb1_wd",  W_WD, 32'h0000_007F);
    chk("lb1_cnt", W_commits, 32'd7);

    // jal $31 and link wrap
    drive(1'b1, 32'h3008, 1'b1, 5'd31, 32'h0, 2'd2, 3'd0);
    tick();
    chk("jal_wd", W_WD, 32'h3010);
    chk("jal_a3", {27'd0, W_A3}, 32'd31);
    drive(1'b1, 32'hFFFF_FFFC, 1'b1, 5'd5, 32'h0, 2'd2, 3'd0);
    tick();
    chk("wrap_wd", W_WD, 32'h0000_0004);
    chk("wrap_pc", W_PC, 32'hFFFF_FFFC);

    // $0 destination, no RegWrite, bubble
    drive(1'b1, 32'h3020, 1'b1, 5'd0, 32'h5555, 2'd0, 3'd0);
    tick();
    chk("a0_we",  {31'd0, W_WE}, 32'd0);
    chk("a0_a3",  {27'd0, W_A3}, 32'd0);
    chk("a0_wd",  W_WD, 32'd0);
    chk("a0_fwd", {31'd0, W_fwd_hit}, 32'd0);
    chk("a0_cnt", W_commits, 32'd10);
    drive(1'b1, 32'h3024, 1'b0, 5'd7, 32'h5555, 2'd0, 3'd0);
    tick();
    chk("norw_we", {31'd0, W_WE}, 32'd0);
    chk("norw_a3", {27'd0, W_A3}, 32'd0);
    drive(1'b0, 32'h3028, 1'b1, 5'd7, 32'h5555, 2'd0, 3'd0);
    tick();
    chk("bub_we",  {31'd0, W_WE}, 32'd0);
    chk("bub_pc",  W_PC, 32'h0000_3000);
    chk("bub_cnt", W_commits, 32'd10);

    // Back-to-back writes after a fresh reset
    reset = 1'b1;
    bubble();
    tick();
    chk("rst2_cnt", W_commits, 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h3100 + 32'(4 * i), 1'b1, 5'(i + 1), 32'(i + 100), 2'd0, 3'd0);
      tick();
      chk($sformatf("b2b%0d_we", i), {31'd0, W_WE}, 32'd1);
      chk($sformatf("b2b%0d_wd", i), W_WD, 32'(i + 100));
    end
    bubble();
    tick();
    chk("b2b3_we",  {31'd0, W_WE}, 32'd0);
    chk("b2b3_cnt", W_commits, 32'd3);
    tick();
    chk("b2b4_cnt", W_commits, 32'd3);

    // Reset on the same edge as a pending write drops it
    drive(1'b1, 32'h3200, 1'b1, 5'd12, 32'hABCD, 2'd0, 3'd0);
    tick();
    chk("pre_rst_we", {31'd0, W_WE}, 32'd1);
    reset = 1'b1;
    drive(1'b1, 32'h3204, 1'b1, 5'd13, 32'hBEEF, 2'd0, 3'd0);
    tick();
    chk("rst_mid_we",  {31'd0, W_WE}, 32'd0);
    chk("rst_mid_cnt", W_commits, 32'd0);
    chk("rst_mid_pc",  W_PC, 32'h0000_3000);
    reset = 1'b0;

    // HI/LO select
    drive(1'b1, 32'h3300, 1'b1, 5'd10, 32'h1234, 2'd3, 3'd0);
    tick();
`ifdef WB_HILO_EN
    chk("hilo_we", {31'd0, W_WE}, 32'd1);
    chk("hilo_wd", W_WD, 32'h0000_DEAD);
`else
    chk("hilo_we", {31'd0, W_WE}, 32'd0);
    chk("hilo_wd", W_WD, 32'd0);
`endif
    bubble();
    tick();
`ifdef WB_HILO_EN
    chk("hilo_cnt", W_commits, 32'd1);
`else
    chk("hilo_cnt", W_commits, 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
